rule110_scan_reader: RTL and testbench

//   Downstream stage of the rule110 automaton core. Freezes the core (halt_n low), sweeps every
//   8-cell block address, captures the core's data_out and streams the full generation as a

---
 rtl/rule110_scan_reader_if.sv | 19 +
 rtl/rule110_scan_reader.sv | 195 +++++++++++++++++++
 tb/tb_rule110_scan_reader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rule110_scan_reader_if.sv
// Byte stream carrying one rule110 generation per frame from the scan
// reader to its consumer (valid/ready, transfer on out_valid && out_ready).
interface rule110_scan_reader_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/rule110_scan_reader.sv
// rule110_scan_reader: freezes the rule110 core, sweeps every 8-cell block
// address, and streams the whole generation as one byte frame. Between
// frames (while run stays high) it releases halt_n so the core advances
// STEPS_PER_FRAME generations.
//
// Optional feature: define RULE110_READER_FRAME_HDR_EN to prefix every frame
// with 0xA5, gen_count[15:8], gen_count[7:0]. Without it there is no header
// and no header logic.
module rule110_scan_reader #(
  parameter int NUM_BLOCKS      = 32,
  parameter int ADDR_W          = 6,
  parameter int SETTLE_CYCLES   = 1,
  parameter int STEPS_PER_FRAME = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [7:0]            core_data_i,
  output logic                  core_we_n_o,
  output logic                  core_halt_n_o,
  output logic [ADDR_W-1:0]     core_addr_o,
  rule110_scan_reader_if.master strm,
  output logic                  busy,
  output logic [15:0]           gen_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_BLOCKS - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]        STEP_LAST   = 8'(STEPS_PER_FRAME - 1);
  localparam logic [15:0]       GEN_INC     = 16'(STEPS_PER_FRAME);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_STEP    = 3'd4,
    S_HDR     = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  state_t      frame_start;
  logic [3:0]  settle_cnt;
  logic [7:0]  step_cnt;
  logic [7:0]  out_data_q;
  logic        out_valid_q;
  logic        xfer;
  logic        last_addr;
  logic        hdr_active;

`ifdef RULE110_READER_FRAME_HDR_EN
  logic [1:0]  hdr_cnt;

  // Header byte for position idx (0..2) of the frame prefix.
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] gen);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'hA5;
      2'd1:    b = gen[15:8];
      default: b = gen[7:0];
    endcase
    return b;
  endfunction

  assign hdr_active  = (hdr_cnt != 2'd3);
  assign frame_start = S_HDR;
`else
  assign hdr_active  = 1'b0;
  assign frame_start = S_SETTLE;
`endif

  assign xfer          = out_valid_q && strm.out_ready;
  assign last_addr     = (core_addr_o == LAST_ADDR);
  assign core_we_n_o   = 1'b1;
  assign strm.out_data  = out_data_q;
  assign strm.out_valid = out_valid_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode: frame sequencing, end-of-frame step/idle decision.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = frame_start;
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
`ifdef RULE110_READER_FRAME_HDR_EN
          if (hdr_active) begin
            state_nxt = (hdr_cnt == 2'd2) ? S_SETTLE : S_HDR;
          end else
`endif
          if (!last_addr) state_nxt = S_SETTLE;
          else if (run)   state_nxt = S_STEP;
          else            state_nxt = S_IDLE;
        end
      end
      S_STEP: begin
        if (step_cnt == STEP_LAST) state_nxt = frame_start;
      end
      S_HDR: begin
        state_nxt = S_SEND;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Settle and step dwell counters restart whenever their state is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= 4'd0;
      step_cnt   <= 8'd0;
    end else begin
      settle_cnt <= (state == S_SETTLE && state_nxt == S_SETTLE) ? settle_cnt + 4'd1 : 4'd0;
      step_cnt   <= (state == S_STEP && state_nxt == S_STEP) ? step_cnt + 8'd1 : 8'd0;
    end
  end

  // Core control: halt_n only high in STEP, address walks block by block.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_halt_n_o <= 1'b0;
      core_addr_o   <= '0;
      busy          <= 1'b0;
    end else begin
      core_halt_n_o <= (state_nxt == S_STEP);
      busy          <= (state_nxt != S_IDLE);
      if (state == S_SEND && state_nxt == S_SETTLE && !hdr_active)
        core_addr_o <= core_addr_o + 1'b1;
      else if (state == S_STEP || state_nxt == S_IDLE)
        core_addr_o <= '0;
    end
  end

  // Generation counter advances once per completed STEP phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_count <= 16'd0;
    end else if (state == S_STEP && state_nxt != S_STEP) begin
      gen_count <= gen_count + GEN_INC;
    end
  end

`ifdef RULE110_READER_FRAME_HDR_EN
  // Header position: rearmed at each frame start, parks at 3 once sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_cnt <= 2'd0;
    end else if (state == S_IDLE || state == S_STEP) begin
      hdr_cnt <= 2'd0;
    end else if (state == S_SEND && xfer && hdr_active) begin
      hdr_cnt <= hdr_cnt + 2'd1;
    end
  end
`endif

  // Output byte register: loaded in CAPTURE (or HDR), held through SEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      if (state == S_CAPTURE) begin
        out_valid_q <= 1'b1;
        out_data_q  <= core_data_i;
      end
`ifdef RULE110_READER_FRAME_HDR_EN
      else if (state == S_HDR) begin
        out_valid_q <= 1'b1;
        out_data_q  <= hdr_byte(hdr_cnt, gen_count);
      end
`endif
      else if (state == S_SEND && xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // The core must stay frozen while a byte of the frame is outstanding.
  assert property (@(posedge clk) disable iff (reset)
    !(core_halt_n_o && out_valid_q));

endmodule

// File: tb/tb_rule110_scan_reader.sv
// Bench for rule110_scan_reader with a behavioural rule110 core (256 cells,
// single seed cell) feeding core_data_i with the next state of each block.
module tb_rule110_scan_reader;
  localparam int ADDR_W = 6;
  localparam int NB     = 32;
  localparam int BYTE_PERIOD = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_rst;
  logic              run;
  logic [7:0]        core_data;
  logic              core_we_n;
  logic              core_halt_n;
  logic [ADDR_W-1:0] core_addr;
  logic              busy;
  logic [15:0]       gen_count;

  int n_checks = 0;
  int n_errors = 0;
  int halt_cnt = 0;
  int halt_viol = 0;

  rule110_scan_reader_if bus ();

  rule110_scan_reader #(
    .NUM_BLOCKS(NB), .ADDR_W(ADDR_W), .SETTLE_CYCLES(1), .STEPS_PER_FRAME(1)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .core_data_i(core_data),
    .core_we_n_o(core_we_n), .core_halt_n_o(core_halt_n), .core_addr_o(core_addr),
    .strm(bus), .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  // Behavioural core: cell i sees (cell i+1, cell i, cell i-1) as (l,c,r).
  logic [255:0] cells;
  logic [255:0] cells_nxt;
  logic [7:0]   rule = 8'h6E;

  always_comb begin
    cells_nxt = '0;
    for (int i = 0; i < 256; i++)
      cells_nxt[i] = rule[{cells[(i + 1) % 256], cells[i], cells[(i + 255) % 256]}];
  end

  assign core_data = cells_nxt[core_addr[4:0]*8 +: 8];

  always @(posedge clk) begin
    if (core_rst)         cells <= 256'd1;
    else if (core_halt_n) cells <= cells_nxt;
  end

  always @(posedge clk) begin
    if (core_halt_n) halt_cnt <= halt_cnt + 1;
    if (core_halt_n && bus.out_valid) halt_viol <= halt_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a transfer, return byte, address and cycles since call.
  task automatic recv(output logic [7:0] d, output logic [ADDR_W-1:0] a, output int cyc);
    int w = 0;
    while (!(bus.out_valid && bus.out_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!(bus.out_valid && bus.out_ready)) check("recv_timeout", 32'(w), 32'd0);
    d   = bus.out_data;
    a   = core_addr;
    cyc = w + 1;
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!bus.out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic recv_hdr(input logic [15:0] exp_gen);
`ifdef RULE110_READER_FRAME_HDR_EN
    logic [7:0] d;
    logic [ADDR_W-1:0] a;
    int c;
    recv(d, a, c); check("hdr_sync", 32'(d), 32'hA5);
    recv(d, a, c); check("hdr_gen_hi", 32'(d), 32'(exp_gen[15:8]));
    recv(d, a, c); check("hdr_gen_lo", 32'(d), 32'(exp_gen[7:0]));
`else
    if (exp_gen === 16'hxxxx) check("hdr_gen_x", 32'(exp_gen), 32'd0);
`endif
  endtask

  task automatic recv_frame(input logic [7:0] exp0, input int k);
    logic [7:0] d;
    logic [ADDR_W-1:0] a;
    int c, nonzero, bad_addr, bad_gap;
    nonzero = 0; bad_addr = 0; bad_gap = 0;
    recv_hdr(16'(k - 1));
    recv(d, a, c);
    check($sformatf("f%0d_byte0", k), 32'(d), 32'(exp0));
    check($sformatf("f%0d_addr0", k), 32'(a), 32'd0);
    check($sformatf("f%0d_gen", k), 32'(gen_count), 32'(k - 1));
    check($sformatf("f%0d_halt_cycles", k), 32'(halt_cnt), 32'(k - 1));
    check($sformatf("f%0d_busy", k), 32'(busy), 32'd1);
    for (int b = 1; b < NB; b++) begin
      recv(d, a, c);
      if (d != 8'h00) nonzero++;
      if (32'(a) != 32'(b)) bad_addr++;
      if (c != BYTE_PERIOD) bad_gap++;
    end
    check($sformatf("f%0d_tail_nonzero", k), 32'(nonzero), 32'd0);
    check($sformatf("f%0d_addr_seq", k), 32'(bad_addr), 32'd0);
    check($sformatf("f%0d_byte_period", k), 32'(bad_gap), 32'd0);
  endtask

  initial begin
    logic [7:0] d, snap_d;
    logic [ADDR_W-1:0] a, snap_a;
    int c, bad_addr, stable, valid_seen, w, halt_before;

    reset = 1'b1; core_rst = 1'b1; run = 1'b0; bus.out_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_halt_n", 32'(core_halt_n), 32'd0);
    check("rst_we_n", 32'(core_we_n), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gen", 32'(gen_count), 32'd0);
    check("rst_addr", 32'(core_addr), 32'd0);
    reset = 1'b0; core_rst = 1'b0;

    // Three back-to-back frames from the seed cell.
    run = 1'b1; bus.out_ready = 1'b1;
    recv_frame(8'h03, 1);
    recv_frame(8'h07, 2);
    recv_frame(8'h0D, 3);

    // Frame 4: stall at byte 5, drop run at byte 10.
    recv_hdr(16'd3);
    recv(d, a, c);
    check("f4_byte0", 32'(d), 32'h1F);
    check("f4_gen", 32'(gen_count), 32'd3);
    for (int b = 1; b < 5; b++) recv(d, a, c);
    bus.out_ready = 1'b0;
    wait_valid();
    snap_d = bus.out_data; snap_a = core_addr; stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== snap_d ||
          core_addr !== snap_a || core_halt_n !== 1'b0) stable = 0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    check("stall_addr", 32'(snap_a), 32'd5);
    bus.out_ready = 1'b1;
    recv(d, a, c);
    check("stall_byte", 32'(d), 32'(snap_d));
    for (int b = 6; b < 10; b++) recv(d, a, c);
    recv(d, a, c);
    check("drop_addr10", 32'(a), 32'd10);
    run = 1'b0;
    halt_before = halt_cnt;
    bad_addr = 0;
    for (int b = 11; b < NB; b++) begin
      recv(d, a, c);
      if (32'(a) != 32'(b)) bad_addr++;
    end
    check("drop_tail_addr", 32'(bad_addr), 32'd0);
    check("drop_last_addr", 32'(a), 32'(NB - 1));
    w = 0;
    while (busy && w < 50) begin @(negedge clk); w++; end
    valid_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) valid_seen++;
    end
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_no_step", 32'(halt_cnt), 32'(halt_before));
    check("drop_gen", 32'(gen_count), 32'd3);
    check("drop_idle_valid", 32'(valid_seen), 32'd0);
    check("drop_idle_addr", 32'(core_addr), 32'd0);

    // Frame 5: reset while byte 5 is presented.
    run = 1'b1;
    recv_hdr(16'd3);
    recv(d, a, c);
    check("f5_byte0", 32'(d), 32'h1F);
    for (int b = 1; b < 5; b++) recv(d, a, c);
    bus.out_ready = 1'b0;
    wait_valid();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_gen", 32'(gen_count), 32'd0);
    reset = 1'b0; bus.out_ready = 1'b1;
    recv_hdr(16'd0);
    recv(d, a, c);
    check("restart_addr", 32'(a), 32'd0);
    check("restart_byte0", 32'(d), 32'h1F);
    recv(d, a, c);
    check("restart_addr1", 32'(a), 32'd1);

    check("halt_vs_valid", 32'(halt_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
